pipeline_stage_sequencer: RTL

// - Parametrised successor to the fixed 5-stage controller: generates per-stage pipeline-register,
//   PC, RAM and register-file write enables for an N-stage core.
// - Runtime mode: sequential (one stage per cycle, multicycle) or pipelined (all stages every cycle).
// - Adds stall, flush, halt, fill tracking and a retire pulse; sits beside the CPU top, driving every *_wren.

---
 rtl/pipeline_stage_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipeline_stage_sequencer.sv
// N-stage pipeline write-enable sequencer: sequential or pipelined mode with stall, flush and halt.
// Optional perf counters are enabled by defining STAGE_SEQ_PERF_COUNTERS_EN.
module pipeline_stage_sequencer #(
   parameter int NUM_STAGES        = 5,
   parameter int MEM_STAGE         = 3,
   parameter int WB_STAGE          = 4,
   parameter int RESET_HOLD_CYCLES = 2,
   parameter int CNT_WIDTH         = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          mode,
   input  logic                          stall,
   input  logic                          flush,
   input  logic                          halt,
   output logic [NUM_STAGES-1:0]         stage_wren,
   output logic                          pc_wren,
   output logic                          ram_wren,
   output logic                          reg_wren,
   output logic                          stage_reset_n,
   output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
   output logic                          instr_retire,
   output logic                          halted,
   output logic [CNT_WIDTH-1:0]          cycle_count,
   output logic [CNT_WIDTH-1:0]          retire_count
);
   localparam int IW = $clog2(NUM_STAGES);
   localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
   localparam logic [IW-1:0] LAST     = IW'(NUM_STAGES - 1);
   localparam logic [HW-1:0] HOLD_END = HW'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_HALTED} state_t;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic [IW-1:0] token;
   logic [IW-1:0] fill;
   logic          mode_q;
   logic          halt_pend;
   logic          rst_pend;

   logic running, boundary, halt_eff, take_halt, can_go, switch_seq, advance, mode_eff;

   // rst_pend marks the single stage_reset_n-low cycle that follows a flush or a pipe->seq switch.
   assign running    = (state == S_RUN) && !rst_pend;
   assign boundary   = mode_q || (token == '0);
   assign halt_eff   = halt_pend || halt;
   assign take_halt  = running && !flush && boundary && halt_eff && !stall;
   assign can_go     = running && !flush && !take_halt && !stall;
   assign switch_seq = can_go && boundary && mode_q && !mode;
   assign advance    = can_go && !switch_seq;
   assign mode_eff   = boundary ? mode : mode_q;

   always_comb begin
      stage_wren   = '0;
      pc_wren      = 1'b0;
      ram_wren     = 1'b0;
      reg_wren     = 1'b0;
      instr_retire = 1'b0;
      if (advance) begin
         if (mode_eff) begin
            stage_wren   = '1;
            pc_wren      = 1'b1;
            ram_wren     = 1'b1;
            reg_wren     = 1'b1;
            instr_retire = (fill == LAST);
         end else begin
            stage_wren   = NUM_STAGES'(1) << token;
            pc_wren      = (token == '0);
            ram_wren     = (token == IW'(MEM_STAGE));
            reg_wren     = (token == IW'(WB_STAGE));
            instr_retire = (token == IW'(WB_STAGE));
         end
      end
   end

   assign stage_reset_n = (state == S_HALTED) || ((state == S_RUN) && !rst_pend);
   assign halted        = (state == S_HALTED);
   assign stage_idx     = mode_q ? '0 : token;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_HOLD;
         hold_cnt  <= '0;
         token     <= '0;
         fill      <= '0;
         mode_q    <= 1'b0;
         halt_pend <= 1'b0;
         rst_pend  <= 1'b0;
      end else begin
         case (state)
            S_HOLD: begin
               halt_pend <= halt_pend | halt;
               if (hold_cnt == HOLD_END) state <= S_RUN;
               else                      hold_cnt <= hold_cnt + 1'b1;
            end
            S_RUN: begin
               halt_pend <= halt_pend | halt;
               rst_pend  <= 1'b0;
               if (rst_pend) begin
                  if (flush) rst_pend <= 1'b1;
               end else if (flush) begin
                  rst_pend <= 1'b1;
                  token    <= '0;
                  fill     <= '0;
               end else if (take_halt) begin
                  state <= S_HALTED;
               end else if (switch_seq) begin
                  rst_pend <= 1'b1;
                  token    <= '0;
                  fill     <= '0;
                  mode_q   <= 1'b0;
               end else if (advance) begin
                  mode_q <= mode_eff;
                  if (mode_eff) begin
                     token <= '0;
                     if (fill != LAST) fill <= fill + 1'b1;
                  end else begin
                     fill  <= '0;
                     token <= (token == LAST) ? '0 : token + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef STAGE_SEQ_PERF_COUNTERS_EN
   logic [CNT_WIDTH-1:0] cyc_q;
   logic [CNT_WIDTH-1:0] ret_q;

   // Stalled RUN cycles count too; HALTED freezes both since neither condition can occur there.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (state == S_RUN) cyc_q <= cyc_q + 1'b1;
         if (instr_retire)   ret_q <= ret_q + 1'b1;
      end
   end

   assign cycle_count  = cyc_q;
   assign retire_count = ret_q;
`else
   assign cycle_count  = '0;
   assign retire_count = '0;
`endif

endmodule
